rx_frame_drop_queue: RTL and testbench

- Store-and-forward receive buffer between the MAC RX interface and the TCP/IP engine.
- Whole-frame drop policy (or backpressure policy), generalised in data width, depth and frame-count capacity.
- Each frame is committed only on its endframe beat. Partial or overflowing frames are rolled back and never reach the engine.
- Frame size travels on a side FIFO and is presented with every beat of its frame, replacing the separate size-queue reader.

---
 rtl/rx_frame_drop_queue.sv | 218 +++++++++++++++++++++
 tb/tb_rx_frame_drop_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_drop_queue.sv
// rx_frame_drop_queue: store-and-forward RX frame buffer between MAC and engine.
// Beats are written speculatively and become visible only when their frame's
// endframe beat commits; overflowing or truncated frames are rolled back.
module rx_frame_drop_queue #(
   parameter int unsigned DATA_W     = 512,
   parameter int unsigned PADBYTES_W = 6,
   parameter int unsigned SIZE_W     = 16,
   parameter int unsigned LOG2_ELS   = 6,
   parameter int unsigned LOG2_PKTS  = 4,
   parameter int unsigned DROP_EN    = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mac_engine_rx_val,
   input  logic [DATA_W-1:0]     mac_engine_rx_data,
   input  logic                  mac_engine_rx_startframe,
   input  logic                  mac_engine_rx_endframe,
   input  logic [PADBYTES_W-1:0] mac_engine_rx_padbytes,
   output logic                  engine_mac_rx_rdy,
   output logic                  queue_engine_rx_val,
   output logic [DATA_W-1:0]     queue_engine_rx_data,
   output logic                  queue_engine_rx_startframe,
   output logic                  queue_engine_rx_endframe,
   output logic [PADBYTES_W-1:0] queue_engine_rx_padbytes,
   output logic [SIZE_W-1:0]     queue_engine_rx_frame_size,
   input  logic                  engine_queue_rx_rdy,
   output logic [CNT_W-1:0]      frames_dropped,
   output logic [CNT_W-1:0]      frames_passed
);
   localparam int unsigned BEAT_BYTES = DATA_W / 8;
   localparam int unsigned PTR_W      = LOG2_ELS + 1;
   localparam int unsigned SPTR_W     = LOG2_PKTS + 1;
   localparam int unsigned ENT_W      = DATA_W + PADBYTES_W + 1;
   localparam logic [PTR_W-1:0]  ELS  = PTR_W'(1) << LOG2_ELS;
   localparam logic [SPTR_W-1:0] PKTS = SPTR_W'(1) << LOG2_PKTS;

   typedef enum logic [1:0] {ST_IDLE, ST_IN_FRAME, ST_DISCARD} state_e;

   logic [ENT_W-1:0]  data_mem [2**LOG2_ELS];
   logic [SIZE_W-1:0] size_mem [2**LOG2_PKTS];

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   spec_ptr_q, spec_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SPTR_W-1:0]  sz_wr_q, sz_wr_d, sz_rd_q, sz_rd_d;
   logic [SIZE_W-1:0]  byte_acc_q, byte_acc_d;
   logic [CNT_W-1:0]   dropped_q, dropped_d, passed_q, passed_d;
   logic               in_rdy_q, in_rdy_d;
   logic               out_vld_q, out_vld_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
   logic               last_eof_q, last_eof_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [PADBYTES_W-1:0] out_pad_q, out_pad_d;
   logic [SIZE_W-1:0]  out_size_q, out_size_d;

   logic               in_acc, ovf, size_full, wr_en, sz_push, pass_inc, out_hs;
   logic [1:0]         drop_inc;
   logic [PTR_W-1:0]   base_ptr, fetch_ptr;
   logic [SIZE_W-1:0]  base_acc, beat_bytes, acc_sum;
   logic [ENT_W-1:0]   wr_ent, rd_ent;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Input FSM: speculative write, commit on endframe, rollback on overflow/truncation
   always_comb begin
      state_d      = state_q;
      spec_ptr_d   = spec_ptr_q;
      commit_ptr_d = commit_ptr_q;
      byte_acc_d   = byte_acc_q;
      sz_wr_d      = sz_wr_q;
      wr_en        = 1'b0;
      sz_push      = 1'b0;
      pass_inc     = 1'b0;
      drop_inc     = 2'd0;
      in_acc       = mac_engine_rx_val & in_rdy_q;
      base_ptr     = mac_engine_rx_startframe ? commit_ptr_q : spec_ptr_q;
      base_acc     = mac_engine_rx_startframe ? '0 : byte_acc_q;
      beat_bytes   = mac_engine_rx_endframe ? SIZE_W'(BEAT_BYTES) - SIZE_W'(mac_engine_rx_padbytes)
                                            : SIZE_W'(BEAT_BYTES);
      acc_sum      = base_acc + beat_bytes;
      size_full    = (sz_wr_q - sz_rd_q) == PKTS;
      ovf          = ((base_ptr - rd_ptr_q) == ELS) | (mac_engine_rx_startframe & size_full);
      wr_ent       = {mac_engine_rx_endframe,
                      mac_engine_rx_endframe ? mac_engine_rx_padbytes : PADBYTES_W'(0),
                      mac_engine_rx_data};
      if (in_acc) begin
         if (mac_engine_rx_startframe && state_q != ST_IDLE) drop_inc = 2'd1;
         if (mac_engine_rx_startframe || state_q == ST_IN_FRAME) begin
            if (ovf) begin
               spec_ptr_d = commit_ptr_q;
               byte_acc_d = '0;
               if (mac_engine_rx_endframe) begin
                  drop_inc = drop_inc + 2'd1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_DISCARD;
               end
            end else begin
               wr_en      = 1'b1;
               spec_ptr_d = base_ptr + PTR_W'(1);
               if (mac_engine_rx_endframe) begin
                  commit_ptr_d = base_ptr + PTR_W'(1);
                  sz_push      = 1'b1;
                  sz_wr_d      = sz_wr_q + SPTR_W'(1);
                  pass_inc     = 1'b1;
                  byte_acc_d   = '0;
                  state_d      = ST_IDLE;
               end else begin
                  byte_acc_d   = acc_sum;
                  state_d      = ST_IN_FRAME;
               end
            end
         end else if (state_q == ST_DISCARD && mac_engine_rx_endframe) begin
            drop_inc = 2'd1;
            state_d  = ST_IDLE;
         end
      end
      dropped_d = sat_add(dropped_q, drop_inc);
      passed_d  = sat_add(passed_q, {1'b0, pass_inc});
   end

   // Output prefetch register always mirrors the beat at rd_ptr
   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_sof_d  = out_sof_q;
      out_eof_d  = out_eof_q;
      out_pad_d  = out_pad_q;
      out_size_d = out_size_q;
      last_eof_d = last_eof_q;
      out_hs     = out_vld_q & engine_queue_rx_rdy;
      rd_ptr_d   = rd_ptr_q + PTR_W'(out_hs);
      sz_rd_d    = sz_rd_q + SPTR_W'(out_hs & out_eof_q);
      fetch_ptr  = rd_ptr_d;
      rd_ent     = data_mem[fetch_ptr[LOG2_ELS-1:0]];
      if (!out_vld_q || out_hs) begin
         out_vld_d = fetch_ptr != commit_ptr_q;
         if (fetch_ptr != commit_ptr_q) begin
            out_data_d = rd_ent[DATA_W-1:0];
            out_pad_d  = rd_ent[DATA_W +: PADBYTES_W];
            out_eof_d  = rd_ent[ENT_W-1];
            out_sof_d  = last_eof_q;
            last_eof_d = rd_ent[ENT_W-1];
            out_size_d = size_mem[sz_rd_d[LOG2_PKTS-1:0]];
         end
      end
   end

   // Input ready: always open when dropping, otherwise blocks on next-cycle fullness
   always_comb begin
      if (DROP_EN != 0) begin
         in_rdy_d = 1'b1;
      end else begin
         in_rdy_d = ((spec_ptr_d - rd_ptr_d) != ELS) &
                    ((state_d == ST_IN_FRAME) | ((sz_wr_d - sz_rd_d) != PKTS));
      end
   end

   // Buffer and size FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en)   data_mem[base_ptr[LOG2_ELS-1:0]] <= wr_ent;
      if (sz_push) size_mem[sz_wr_q[LOG2_PKTS-1:0]] <= acc_sum;
   end

   // State, pointer, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         spec_ptr_q   <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         sz_wr_q      <= '0;
         sz_rd_q      <= '0;
         byte_acc_q   <= '0;
         dropped_q    <= '0;
         passed_q     <= '0;
         in_rdy_q     <= 1'b0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         out_pad_q    <= '0;
         out_size_q   <= '0;
         last_eof_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         spec_ptr_q   <= spec_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         sz_wr_q      <= sz_wr_d;
         sz_rd_q      <= sz_rd_d;
         byte_acc_q   <= byte_acc_d;
         dropped_q    <= dropped_d;
         passed_q     <= passed_d;
         in_rdy_q     <= in_rdy_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_sof_q    <= out_sof_d;
         out_eof_q    <= out_eof_d;
         out_pad_q    <= out_pad_d;
         out_size_q   <= out_size_d;
         last_eof_q   <= last_eof_d;
      end
   end

   assign engine_mac_rx_rdy          = in_rdy_q;
   assign queue_engine_rx_val        = out_vld_q;
   assign queue_engine_rx_data       = out_data_q;
   assign queue_engine_rx_startframe = out_sof_q;
   assign queue_engine_rx_endframe   = out_eof_q;
   assign queue_engine_rx_padbytes   = out_pad_q;
   assign queue_engine_rx_frame_size = out_size_q;
   assign frames_dropped             = dropped_q;
   assign frames_passed              = passed_q;
endmodule

// File: tb/tb_rx_frame_drop_queue.sv
// Bench for rx_frame_drop_queue: directed table, corner sequences, random vs model.
module tb_rx_frame_drop_queue;
   localparam int unsigned DW = 512, PW = 6, SW = 16, LE = 4, LP = 2;
   localparam int unsigned DEPTH = 1 << LE, NPKT = 1 << LP, BB = DW / 8;
   localparam int S_IDLE = 0, S_IN = 1, S_DISC = 2;

   typedef struct {
      logic [DW-1:0] d;
      logic sof;
      logic eof;
      logic [PW-1:0] pad;
      logic [SW-1:0] size;
   } beat_t;

   typedef struct {
      logic val, sof, eof;
      logic [PW-1:0] pad;
      int unsigned dk;
      logic ordy;
      logic e_val, e_sof, e_eof;
      logic [PW-1:0] e_pad;
      logic [SW-1:0] e_size;
      int unsigned e_dk;
      logic [31:0] e_pass;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: dropping variant
   logic a_val = 0, a_sof = 0, a_eof = 0, a_ordy = 0;
   logic [DW-1:0] a_data = '0;
   logic [PW-1:0] a_pad = '0;
   logic a_irdy, a_oval, a_osof, a_oeof;
   logic [DW-1:0] a_odata;
   logic [PW-1:0] a_opad;
   logic [SW-1:0] a_osize;
   logic [31:0] a_drop, a_pass;

   // DUT B: backpressure variant with narrow counters
   logic b_val = 0, b_sof = 0, b_eof = 0, b_ordy = 0;
   logic [DW-1:0] b_data = '0;
   logic [PW-1:0] b_pad = '0;
   logic b_irdy, b_oval, b_osof, b_oeof;
   logic [DW-1:0] b_odata;
   logic [PW-1:0] b_opad;
   logic [SW-1:0] b_osize;
   logic [1:0] b_drop, b_pass;

   rx_frame_drop_queue #(.DATA_W(DW), .PADBYTES_W(PW), .SIZE_W(SW), .LOG2_ELS(LE),
                         .LOG2_PKTS(LP), .DROP_EN(1), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .mac_engine_rx_val(a_val), .mac_engine_rx_data(a_data),
      .mac_engine_rx_startframe(a_sof), .mac_engine_rx_endframe(a_eof),
      .mac_engine_rx_padbytes(a_pad), .engine_mac_rx_rdy(a_irdy),
      .queue_engine_rx_val(a_oval), .queue_engine_rx_data(a_odata),
      .queue_engine_rx_startframe(a_osof), .queue_engine_rx_endframe(a_oeof),
      .queue_engine_rx_padbytes(a_opad), .queue_engine_rx_frame_size(a_osize),
      .engine_queue_rx_rdy(a_ordy), .frames_dropped(a_drop), .frames_passed(a_pass));

   rx_frame_drop_queue #(.DATA_W(DW), .PADBYTES_W(PW), .SIZE_W(SW), .LOG2_ELS(LE),
                         .LOG2_PKTS(LP), .DROP_EN(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .mac_engine_rx_val(b_val), .mac_engine_rx_data(b_data),
      .mac_engine_rx_startframe(b_sof), .mac_engine_rx_endframe(b_eof),
      .mac_engine_rx_padbytes(b_pad), .engine_mac_rx_rdy(b_irdy),
      .queue_engine_rx_val(b_oval), .queue_engine_rx_data(b_odata),
      .queue_engine_rx_startframe(b_osof), .queue_engine_rx_endframe(b_oeof),
      .queue_engine_rx_padbytes(b_opad), .queue_engine_rx_frame_size(b_osize),
      .engine_queue_rx_rdy(b_ordy), .frames_dropped(b_drop), .frames_passed(b_pass));

   int n_vec = 0, n_mis = 0;
   beat_t got[$];
   beat_t mq[$];
   logic [DW-1:0] cur[$];
   int m_state, m_frames, m_drop, m_pass;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int unsigned k);
      return {(DW/32){k}};
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic beat_t mk(input logic [DW-1:0] d, input logic sof, eof,
                                input logic [PW-1:0] pad, input int unsigned size);
      beat_t b;
      b.d = d; b.sof = sof; b.eof = eof; b.pad = pad; b.size = SW'(size);
      return b;
   endfunction

   task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
      chk({nm, " data"}, act.d, exp.d);
      chk({nm, " sof/eof/pad/size"}, {act.sof, act.eof, act.pad, act.size},
          {exp.sof, exp.eof, exp.pad, exp.size});
   endtask

   task automatic do_reset();
      a_val = 0; a_sof = 0; a_eof = 0; a_ordy = 0;
      b_val = 0; b_sof = 0; b_eof = 0; b_ordy = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic a_beat(input logic sof, eof, input logic [PW-1:0] pad, input logic [DW-1:0] d);
      a_val = 1; a_sof = sof; a_eof = eof; a_pad = pad; a_data = d;
      @(negedge clk);
      a_val = 0; a_sof = 0; a_eof = 0; a_pad = '0;
   endtask

   task automatic b_push(input logic sof, eof, input logic [PW-1:0] pad, input logic [DW-1:0] d);
      int w;
      w = 0;
      while (!b_irdy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!b_irdy) begin
         n_vec++; n_mis++;
         $display("FAIL b_push timeout: in_rdy got 0 expected 1");
      end else begin
         b_val = 1; b_sof = sof; b_eof = eof; b_pad = pad; b_data = d;
         @(negedge clk);
         b_val = 0; b_sof = 0; b_eof = 0; b_pad = '0;
      end
   endtask

   task automatic drain_a(input int ncyc);
      got.delete();
      a_ordy = 1;
      repeat (ncyc) begin
         if (a_oval) got.push_back(mk(a_odata, a_osof, a_oeof, a_opad, a_osize));
         @(negedge clk);
      end
      a_ordy = 0;
   endtask

   task automatic drain_b(input int ncyc);
      got.delete();
      b_ordy = 1;
      repeat (ncyc) begin
         if (b_oval) got.push_back(mk(b_odata, b_osof, b_oeof, b_opad, b_osize));
         @(negedge clk);
      end
      b_ordy = 0;
   endtask

   task automatic model_commit(input logic [PW-1:0] pad);
      int unsigned n, sz;
      n = cur.size();
      sz = n * BB - pad;
      for (int i = 0; i < int'(n); i++)
         mq.push_back(mk(cur[i], i == 0, i == int'(n) - 1, (i == int'(n) - 1) ? pad : PW'(0), sz));
      cur.delete();
      m_frames++;
      m_pass++;
      m_state = S_IDLE;
   endtask

   task automatic model_in(input logic sof, eof, input logic [PW-1:0] pad, input logic [DW-1:0] d);
      if (sof) begin
         if (m_state != S_IDLE) m_drop++;
         cur.delete();
         if (mq.size() == DEPTH || m_frames == NPKT) begin
            if (eof) begin m_drop++; m_state = S_IDLE; end
            else m_state = S_DISC;
         end else begin
            cur.push_back(d);
            if (eof) model_commit(pad);
            else m_state = S_IN;
         end
      end else if (m_state == S_IN) begin
         if (mq.size() + cur.size() == DEPTH) begin
            cur.delete();
            if (eof) begin m_drop++; m_state = S_IDLE; end
            else m_state = S_DISC;
         end else begin
            cur.push_back(d);
            if (eof) model_commit(pad);
         end
      end else if (m_state == S_DISC && eof) begin
         m_drop++;
         m_state = S_IDLE;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // val sof eof pad dk ordy | e_val e_sof e_eof e_pad e_size e_dk e_pass
      tbl[0] = '{1, 1, 0, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0};
      tbl[1] = '{1, 0, 0, 0,  2, 0, 0, 0, 0, 0,   0, 0, 0};
      tbl[2] = '{1, 0, 1, 10, 3, 0, 0, 0, 0, 0,   0, 0, 1};
      tbl[3] = '{0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 182, 1, 1};
      tbl[4] = '{0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 182, 1, 1};
      tbl[5] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 182, 2, 1};
      tbl[6] = '{0, 0, 0, 0,  0, 1, 1, 0, 1, 10, 182, 3, 1};
      tbl[7] = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0,   0, 0, 1};

      // Reset state while rst_n is held low
      rst_n = 0;
      repeat (2) @(negedge clk);
      chk("reset out_val", a_oval, 0);
      chk("reset in_rdy", a_irdy, 0);
      chk("reset counters", {a_drop, a_pass}, 0);
      rst_n = 1;
      @(negedge clk);
      chk("post-reset in_rdy", a_irdy, 1);

      // 3-beat frame, padbytes=10: latency, beat integrity and frame size
      for (int i = 0; i < 8; i++) begin
         a_val = tbl[i].val; a_sof = tbl[i].sof; a_eof = tbl[i].eof;
         a_pad = tbl[i].pad; a_data = pat(tbl[i].dk); a_ordy = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d in_rdy", i), a_irdy, 1);
         chk($sformatf("vec%0d out_val", i), a_oval, tbl[i].e_val);
         chk($sformatf("vec%0d passed", i), a_pass, tbl[i].e_pass);
         if (tbl[i].e_val)
            chk_beat($sformatf("vec%0d beat", i), mk(a_odata, a_osof, a_oeof, a_opad, a_osize),
                     mk(pat(tbl[i].e_dk), tbl[i].e_sof, tbl[i].e_eof, tbl[i].e_pad, tbl[i].e_size));
      end
      a_val = 0; a_sof = 0; a_eof = 0; a_ordy = 0;

      // Data buffer overflow: 4th 5-beat frame dropped whole
      do_reset();
      for (int f = 0; f < 4; f++)
         for (int b = 0; b < 5; b++) a_beat(b == 0, b == 4, 0, pat(f * 16 + b));
      chk("ovf dropped", a_drop, 1);
      chk("ovf passed", a_pass, 3);
      drain_a(15);
      chk("ovf beats out", got.size(), 15);
      for (int j = 0; j < got.size() && j < 15; j++)
         chk_beat($sformatf("ovf beat%0d", j), got[j],
                  mk(pat((j / 5) * 16 + j % 5), j % 5 == 0, j % 5 == 4, 0, 5 * BB));
      chk("ovf val after drain", a_oval, 0);

      // Size FIFO full: 5th single-beat frame dropped
      do_reset();
      for (int i = 0; i < 5; i++) a_beat(1, 1, PW'(i + 1), pat(100 + i));
      chk("szfull dropped", a_drop, 1);
      chk("szfull passed", a_pass, 4);
      drain_a(8);
      chk("szfull beats out", got.size(), 4);
      for (int j = 0; j < got.size() && j < 4; j++)
         chk_beat($sformatf("szfull beat%0d", j), got[j], mk(pat(100 + j), 1, 1, PW'(j + 1), BB - (j + 1)));

      // Truncation: startframe after 2 beats drops the first frame
      do_reset();
      a_ordy = 1;
      a_beat(1, 0, 0, pat(1));
      a_beat(0, 0, 0, pat(2));
      a_beat(1, 0, 0, pat(10));
      a_beat(0, 0, 0, pat(11));
      a_beat(0, 1, 0, pat(12));
      drain_a(8);
      chk("trunc dropped", a_drop, 1);
      chk("trunc passed", a_pass, 1);
      chk("trunc beats out", got.size(), 3);
      for (int j = 0; j < got.size() && j < 3; j++)
         chk_beat($sformatf("trunc beat%0d", j), got[j], mk(pat(10 + j), j == 0, j == 2, 0, 3 * BB));

      // Asynchronous reset mid-frame
      do_reset();
      a_beat(0, 1, 0, pat(7));
      a_beat(1, 1, 0, pat(50));
      a_beat(1, 0, 0, pat(51));
      a_beat(0, 0, 0, pat(52));
      chk("pre-areset out_val", a_oval, 1);
      chk("stray eof ignored", {a_drop, a_pass}, {32'd0, 32'd1});
      #2 rst_n = 0;
      #1;
      chk("areset out_val", a_oval, 0);
      chk("areset in_rdy", a_irdy, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("areset counters", {a_drop, a_pass}, 0);
      drain_a(10);
      chk("areset stale beats", got.size(), 0);
      a_beat(1, 1, 3, pat(60));
      drain_a(6);
      chk("areset fresh beats", got.size(), 1);
      if (got.size() == 1) chk_beat("areset fresh", got[0], mk(pat(60), 1, 1, 3, BB - 3));

      // Backpressure variant: rdy falls at 16 beats, no loss, counters saturate
      do_reset();
      for (int k = 0; k < 16; k++) begin
         if (k == 15) chk("bp in_rdy at 15", b_irdy, 1);
         b_push(k % 8 == 0, k % 8 == 7, 0, pat(200 + k));
      end
      chk("bp in_rdy at 16", b_irdy, 0);
      repeat (3) @(negedge clk);
      chk("bp in_rdy held", b_irdy, 0);
      drain_b(20);
      chk("bp beats out", got.size(), 16);
      for (int j = 0; j < got.size() && j < 16; j++)
         chk_beat($sformatf("bp beat%0d", j), got[j], mk(pat(200 + j), j % 8 == 0, j % 8 == 7, 0, 8 * BB));
      chk("bp counters", {b_drop, b_pass}, {2'd0, 2'd2});
      chk("bp in_rdy after drain", b_irdy, 1);
      b_ordy = 1;
      b_push(1, 1, 0, pat(300));
      b_push(1, 1, 0, pat(301));
      for (int k = 0; k < 4; k++) b_push(1, 0, 0, pat(310 + k));
      b_push(1, 1, 0, pat(320));
      repeat (4) @(negedge clk);
      chk("bp passed saturates", b_pass, 3);
      chk("bp dropped saturates", b_drop, 3);
      b_ordy = 0;

      // Random traffic against the reference model
      do_reset();
      mq.delete(); cur.delete();
      m_state = S_IDLE; m_frames = 0; m_drop = 0; m_pass = 0;
      for (int cyc = 0; cyc < 4060; cyc++) begin
         logic v, s, e, hs;
         logic [PW-1:0] p;
         logic [DW-1:0] d;
         beat_t ex;
         chk("rnd in_rdy", a_irdy, 1);
         chk("rnd dropped", a_drop, m_drop);
         chk("rnd passed", a_pass, m_pass);
         v = (cyc < 4000) && ($urandom_range(99) < 70);
         s = $urandom_range(99) < 20;
         e = $urandom_range(99) < 30;
         p = e ? PW'($urandom_range(63)) : PW'(0);
         d = rnd_data();
         a_val = v; a_sof = s; a_eof = e; a_pad = p; a_data = d;
         a_ordy = (cyc >= 4000) || ($urandom_range(99) < ((cyc % 400 < 200) ? 20 : 70));
         hs = a_oval && a_ordy;
         if (a_oval) chk("rnd val implies committed", mq.size() != 0, 1);
         if (v) model_in(s, e, p, d);
         if (hs && mq.size() != 0) begin
            ex = mq.pop_front();
            chk_beat("rnd beat", mk(a_odata, a_osof, a_oeof, a_opad, a_osize), ex);
            if (ex.eof) m_frames--;
         end
         @(negedge clk);
      end
      a_val = 0; a_sof = 0; a_eof = 0; a_ordy = 0;
      chk("rnd final dropped", a_drop, m_drop);
      chk("rnd final passed", a_pass, m_pass);
      chk("rnd residual beats", mq.size(), 0);
      chk("rnd final val", a_oval, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
